seg_display_ctrl: RTL

Sequenced front end for the board's four-digit seven-segment display. Accepts a W-bit unsigned binary value over a valid/ready handshake and converts it to packed BCD with a multi-cycle shift-and-add-3 (double dabble) engine, one bit per clock. It holds the converted digits and time-multiplexes them onto the shared `an`/`seg` pins with a free-running scan prescaler. It sits between the lab datapath result bus and the board pins, and replaces the combinational converter plus the ad-hoc scan logic.

---
 rtl/seg_pkg.sv | 58 +++++
 rtl/bcd_shift_conv.sv | 80 ++++++++
 rtl/seg_display_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants, FSM state encodings and helpers for the seven-segment display front end.
package seg_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        CS_IDLE  = ST_IDLE,
        CS_SHIFT = ST_SHIFT,
        CS_DONE  = ST_DONE
    } conv_state_e;

    // Digit enables, active-low; DIG3 is the thousands position.
    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG0 = 4'b1110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_D0 = ~7'h3F;
    localparam logic [6:0] SEG_D1 = ~7'h06;
    localparam logic [6:0] SEG_D2 = ~7'h5B;
    localparam logic [6:0] SEG_D3 = ~7'h4F;
    localparam logic [6:0] SEG_D4 = ~7'h66;
    localparam logic [6:0] SEG_D5 = ~7'h6D;
    localparam logic [6:0] SEG_D6 = ~7'h7D;
    localparam logic [6:0] SEG_D7 = ~7'h07;
    localparam logic [6:0] SEG_D8 = ~7'h7F;
    localparam logic [6:0] SEG_D9 = ~7'h6F;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        case (nibble)
            4'd0:    seg_decode = SEG_D0;
            4'd1:    seg_decode = SEG_D1;
            4'd2:    seg_decode = SEG_D2;
            4'd3:    seg_decode = SEG_D3;
            4'd4:    seg_decode = SEG_D4;
            4'd5:    seg_decode = SEG_D5;
            4'd6:    seg_decode = SEG_D6;
            4'd7:    seg_decode = SEG_D7;
            4'd8:    seg_decode = SEG_D8;
            4'd9:    seg_decode = SEG_D9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: any BCD nibble above 4 would overflow on the next shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd4) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_shift_conv.sv
// Handshake, FSM and one-bit-per-clock shift-and-add-3 binary to BCD engine.
module bcd_shift_conv
    import seg_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         mclk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_bin,
    output logic         busy,
    output logic [15:0]  bcd_out,
    output logic         bcd_valid,
    output conv_state_e  state_dbg
);

    // Handshake: a value transfers on a rising mclk edge where in_valid and
    // in_ready are both high; in_ready is high only in IDLE, and the source
    // must hold in_bin stable until that edge.

    localparam int CW = $clog2(W + 1);

    logic [1:0]      state;
    logic [W-1:0]    bin_sr;
    logic [15:0]     scratch;
    logic [CW-1:0]   bit_cnt;
    logic [15:0]     adj;
    logic [15+W:0]   sr_nxt;

    always_comb begin
        adj    = bcd_adjust(scratch);
        sr_nxt = {adj, bin_sr} << 1;
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bin_sr    <= '0;
            scratch   <= '0;
            bit_cnt   <= '0;
            bcd_out   <= 16'h0000;
            bcd_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state   <= ST_SHIFT;
                        bin_sr  <= in_bin;
                        scratch <= 16'h0000;
                        bit_cnt <= CW'(W);
                    end
                end
                ST_SHIFT: begin
                    scratch <= sr_nxt[15+W:W];
                    bin_sr  <= sr_nxt[W-1:0];
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == CW'(1)) begin
                        state     <= ST_DONE;
                        bcd_out   <= sr_nxt[15+W:W];
                        bcd_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    bcd_valid <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    bcd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_SHIFT) || (state == ST_DONE);
    assign state_dbg = conv_state_e'(state);

endmodule

// File: rtl/seg_display_ctrl.sv
// Four-digit seven-segment front end: BCD conversion plus scanned, registered an/seg drive.
// Optional build macro SEG_LZ_BLANK_EN blanks leading zeros on the upper three digits.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int W         = 10,
    parameter int SCAN_BITS = 17
) (
    input  logic         mclk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_bin,
    output logic         busy,
    output logic [15:0]  bcd_out,
    output logic         bcd_valid,
    output logic [3:0]   an,
    output logic [6:0]   seg,
    output logic         dp,
    output conv_state_e  state_dbg
);

    logic [SCAN_BITS+1:0] scan_cnt;
    logic [1:0]           sel;
    logic [3:0]           lz;
    logic [3:0]           an_nxt;
    logic [3:0]           nib;
    logic                 blank;
    logic [6:0]           seg_nxt;

    bcd_shift_conv #(.W(W)) u_conv (
        .mclk      (mclk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .busy      (busy),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .state_dbg (state_dbg)
    );

    assign sel = scan_cnt[SCAN_BITS+1 -: 2];

    // Only the registered bcd_out is ever shown, so a conversion in flight cannot tear the display.
    always_comb begin
        lz = 4'b0000;
`ifdef SEG_LZ_BLANK_EN
        lz[3] = (bcd_out[15:12] == 4'd0);
        lz[2] = lz[3] && (bcd_out[11:8] == 4'd0);
        lz[1] = lz[2] && (bcd_out[7:4] == 4'd0);
`endif
        an_nxt = AN_OFF;
        nib    = 4'd0;
        blank  = 1'b0;
        case (sel)
            2'd0: begin an_nxt = AN_DIG3; nib = bcd_out[15:12]; blank = lz[3]; end
            2'd1: begin an_nxt = AN_DIG2; nib = bcd_out[11:8];  blank = lz[2]; end
            2'd2: begin an_nxt = AN_DIG1; nib = bcd_out[7:4];   blank = lz[1]; end
            default: begin an_nxt = AN_DIG0; nib = bcd_out[3:0]; blank = lz[0]; end
        endcase
        seg_nxt = blank ? SEG_BLANK : seg_decode(nib);
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            an       <= AN_OFF;
            seg      <= SEG_BLANK;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            an       <= an_nxt;
            seg      <= seg_nxt;
        end
    end

    assign dp = 1'b1;

endmodule
